// File: rtl/pixel_renderer.sv
// Pixel-request responder: composites player, enemies and projectile (4x scaled)
// onto the 640x480 raster, with HOME/END screens and per-frame state latching.
module pixel_renderer #(
    parameter int H_VIS    = 640,
    parameter int V_VIS    = 480,
    parameter int ENEMY_W  = 8,
    parameter int PLAYER_W = 8,
    parameter int PROJ_H   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_ce,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    input  logic [1:0]  mode,
    input  logic [7:0]  user_x,
    input  logic [6:0]  user_y,
    input  logic [23:0] enemy_x,
    input  logic [23:0] enemy_y,
    input  logic [2:0]  enemy_exists,
    input  logic [7:0]  proj_x,
    input  logic [7:0]  proj_y,
    input  logic        proj_exists,
    output logic [7:0]  color_out,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        SCREEN_HOME = 2'd0,
        SCREEN_PLAY = 2'd1,
        SCREEN_END  = 2'd2
    } screen_t;

    localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
    localparam logic [8:0] ENEMY_SPAN  = 9'(ENEMY_W - 1);
    localparam logic [8:0] PLAYER_SPAN = 9'(PLAYER_W - 1);
    localparam logic [8:0] PROJ_SPAN   = 9'(PROJ_H - 1);

    localparam logic [7:0] COL_BLACK  = 8'h00;
    localparam logic [7:0] COL_WHITE  = 8'hFF;
    localparam logic [7:0] COL_RED    = 8'hE0;
    localparam logic [7:0] COL_YELLOW = 8'hFC;
    localparam logic [7:0] COL_GREEN  = 8'h1C;

    // Shadowed game state, refreshed only at the frame latch
    screen_t     mode_s;
    logic [7:0]  user_x_s;
    logic [6:0]  user_y_s;
    logic [23:0] enemy_x_s;
    logic [23:0] enemy_y_s;
    logic [2:0]  enemy_exists_s;
    logic [7:0]  proj_x_s;
    logic [7:0]  proj_y_s;
    logic        proj_exists_s;
    logic [5:0]  frame_cnt;

    logic latch_fire;
    assign latch_fire = pix_ce && (next_y == V_VIS_W) && (next_x == 10'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_s         <= SCREEN_HOME;
            user_x_s       <= '0;
            user_y_s       <= '0;
            enemy_x_s      <= '0;
            enemy_y_s      <= '0;
            enemy_exists_s <= '0;
            proj_x_s       <= '0;
            proj_y_s       <= '0;
            proj_exists_s  <= 1'b0;
            frame_cnt      <= '0;
            frame_tick     <= 1'b0;
        end else begin
            frame_tick <= latch_fire;
            if (latch_fire) begin
                mode_s         <= (mode == 2'd3) ? SCREEN_HOME : screen_t'(mode);
                user_x_s       <= user_x;
                user_y_s       <= user_y;
                enemy_x_s      <= enemy_x;
                enemy_y_s      <= enemy_y;
                enemy_exists_s <= enemy_exists;
                proj_x_s       <= proj_x;
                proj_y_s       <= proj_y;
                proj_exists_s  <= proj_exists;
                frame_cnt      <= frame_cnt + 6'd1;
            end
        end
    end

    // Stage 1 hit tests; all limits are 9 bits so boxes clip instead of wrapping
    logic [8:0] gx9, gy9;
    logic       vis_c, player_c, proj_c;
    logic [2:0] enemy_c;

    always_comb begin
        logic [8:0] px_lo, py_lo, py_hi, ex_lo, ey_lo, qx, qy_lo;
        gx9   = {1'b0, next_x[9:2]};
        gy9   = {1'b0, next_y[9:2]};
        vis_c = (next_x < H_VIS_W) && (next_y < V_VIS_W);

        px_lo    = {1'b0, user_x_s};
        py_hi    = {2'b00, user_y_s};
        py_lo    = (user_y_s >= 7'd3) ? {2'b00, user_y_s - 7'd3} : 9'd0;
        player_c = (gx9 >= px_lo) && (gx9 <= px_lo + PLAYER_SPAN) &&
                   (gy9 >= py_lo) && (gy9 <= py_hi);

        enemy_c = '0;
        for (int n = 0; n < 3; n++) begin
            ex_lo = {1'b0, enemy_x_s[8*n +: 8]};
            ey_lo = {1'b0, enemy_y_s[8*n +: 8]};
            enemy_c[n] = enemy_exists_s[n] &&
                         (gx9 >= ex_lo) && (gx9 <= ex_lo + ENEMY_SPAN) &&
                         (gy9 >= ey_lo) && (gy9 <= ey_lo + ENEMY_SPAN);
        end

        qx     = {1'b0, proj_x_s};
        qy_lo  = {1'b0, proj_y_s};
        proj_c = proj_exists_s && (gx9 == qx) &&
                 (gy9 >= qy_lo) && (gy9 <= qy_lo + PROJ_SPAN);
    end

    logic       s1_valid, s1_vis, s1_player, s1_proj, s1_blink;
    logic [2:0] s1_enemy;
    screen_t    s1_mode;

    // Mode and blink phase travel with the pixel so stage 2 never sees a newer latch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_vis    <= 1'b0;
            s1_player <= 1'b0;
            s1_proj   <= 1'b0;
            s1_enemy  <= '0;
            s1_blink  <= 1'b0;
            s1_mode   <= SCREEN_HOME;
        end else if (pix_ce) begin
            s1_valid  <= 1'b1;
            s1_vis    <= vis_c;
            s1_player <= player_c;
            s1_proj   <= proj_c;
            s1_enemy  <= enemy_c;
            s1_blink  <= frame_cnt[5];
            s1_mode   <= mode_s;
        end
    end

    logic [7:0] color_c;

    always_comb begin
        color_c = COL_BLACK;
        if (s1_valid && s1_vis) begin
            case (s1_mode)
                SCREEN_PLAY: begin
                    if (s1_proj)          color_c = COL_YELLOW;
                    else if (s1_player)   color_c = COL_GREEN;
                    else if (|s1_enemy)   color_c = COL_RED;
                    else                  color_c = COL_BLACK;
                end
                SCREEN_END:  color_c = s1_blink ? COL_BLACK : COL_RED;
                default:     color_c = COL_WHITE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_out <= COL_BLACK;
        end else if (pix_ce) begin
            color_out <= color_c;
        end
    end

endmodule

// File: doc/pixel_renderer.md
Name: pixel_renderer

Overview:
- Responder side of the VGA pixel-request interface. The VGA driver issues next_x/next_y; this block returns the 8-bit RGB332 colour for that pixel.
- Composites the player, three enemies and the projectile from 160x120 game coordinates onto the 640x480 raster, using a 4x scale.
- Shows full-screen HOME and END screens.
- Latches all game state once per frame, at the start of vertical blanking, so no object tears mid-frame.

Parameters:
- H_VIS, 640, visible pixels per line.
- V_VIS, 480, visible lines per frame.
- ENEMY_W, 8, enemy box width/height in game units.
- PLAYER_W, 8, player box width in game units (height fixed at 4).
- PROJ_H, 3, projectile box height in game units (width 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- pix_ce  in  1  pixel strobe; one pulse per VGA pixel (25 MHz-rate enable in the clk domain).
- next_x  in  10  requested pixel column from the VGA driver.
- next_y  in  10  requested pixel row from the VGA driver.
- mode  in  2  game screen: 0 HOME, 1 PLAY, 2 END, 3 treated as HOME.
- user_x  in  8  player left edge, game units.
- user_y  in  7  player bottom row, game units.
- enemy_x  in  24  {e3,e2,e1} 8-bit left edges.
- enemy_y  in  24  {e3,e2,e1} 8-bit top edges.
- enemy_exists  in  3  per-enemy draw enable.
- proj_x  in  8  projectile column.
- proj_y  in  8  projectile top row.
- proj_exists  in  1  projectile draw enable.
- color_out  out  8  RGB332 colour for the driver's color_in.
- frame_tick  out  1  one-clk pulse at each frame latch.

Behaviour:
- All state advances only on clk edges where pix_ce=1, except frame_tick, which is a single clk-wide pulse.
- Reset (asynchronous, any time, including mid-frame):
  - color_out=0x00, frame_tick=0.
  - All shadow registers 0; latched mode=HOME.
  - frame_cnt=0; pipeline valid flags cleared.
- Frame latch:
  - Fires when pix_ce=1, next_y==V_VIS and next_x==0.
  - Copies every game input, including mode, into shadow registers.
  - Increments the 6-bit frame_cnt, which wraps 63->0.
  - Pulses frame_tick.
  - Inputs that change at any other time have no effect until the next latch.
- Stage 1 (registered on pix_ce):
  - vis = (next_x<H_VIS) && (next_y<V_VIS).
  - gx = next_x[9:2], gy = next_y[9:2].
  - Per-object hit flags, all using shadowed values.
  - All box limits are computed 9 bits wide: no wrap, and objects past 159/119 clip naturally.
  - Player hit: gx in [user_x, user_x+PLAYER_W-1] and gy in [user_y-3, user_y]. The lower y bound saturates at 0.
  - Enemy n hit: exists[n] and gx in [ex, ex+ENEMY_W-1] and gy in [ey, ey+ENEMY_W-1].
  - Projectile hit: proj_exists and gx==proj_x and gy in [proj_y, proj_y+PROJ_H-1].
- Stage 2 (registered on pix_ce), colour selection in priority order:
  - !vis -> 0x00.
  - HOME -> 0xFF.
  - END -> frame_cnt[5] ? 0x00 : 0xE0 (blinks with a 64-frame period).
  - PLAY, projectile -> 0xFC.
  - PLAY, player -> 0x1C.
  - PLAY, enemy 1/2/3 -> 0xE0.
  - PLAY, none -> background 0x00.
- Latency:
  - color_out for a given (next_x, next_y) is valid exactly 2 pix_ce strobes after that request.
  - The driver's next_x/next_y lead compensates for this.
- Overlaps resolve strictly by the priority above; simultaneous hits never blend.
- A latch coinciding with a stage-1 evaluation: the pixel at (0, V_VIS) is non-visible, so no visible pixel ever mixes old and new state.
- Between reset and the first latch, mode=HOME, so visible pixels render 0xFF after 2 strobes.

Test Plan:
- Reset mid-frame with pix_ce running -> color_out=0x00 immediately. Visible pixels read 0xFF from the second strobe after release. frame_tick stays 0 until next_y=480, next_x=0.
- mode=1, user_x=76, user_y=119, nothing else, latch, then scan pixel (304,476) -> 0x1C. Pixel (335,479) -> 0x1C. Pixel (336,479) -> 0x00. Each arrives 2 strobes after its request.
- mode=1, enemy1 at (10,10) exists, projectile at (12,12) exists -> pixel (48,48) gives 0xFC (projectile wins). Pixel (44,44) gives 0xE0. With enemy_exists=0 the same pixel gives 0x00.
- Enemy at (156,116) -> pixels up to x=639/y=479 red. No wrap artefacts at x=0 or y=0.
- Change user_x from 20 to 100 mid-frame -> the current frame still draws at 20; the next frame draws at 100 after frame_tick.
- mode=2 over 128 frames -> frames 0-31 and 64-95 give 0xE0; frames 32-63 and 96-127 give 0x00. Non-visible pixels give 0x00 throughout.
